seq_ctrl: RTL and testbench
===========================

# seq_ctrl

Stage sequencer and status controller for the sequential Y86-64 core. It owns the architectural PC and the processor status code (AOK/HLT/ADR/INS). It steps the fetch, decode, execute, memory, writeback and PC-update units through one instruction at a time using one-hot stage enables. It also handles a variable-latency data-memory handshake and keeps cycle and retired-instruction counters for the bench and debug.

## Interface
- PC_W, 64, PC width
- CNT_W, 32, width of cycle and instruction counters
- RESET_PC, 0, PC value loaded on reset
- MEM_TIMEOUT, 15, maximum wait cycles for dmem_ack before an ADR fault
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; leave IDLE and begin executing at pc
- stop  in  1  level; sampled in PCUPD; return to IDLE at the instruction boundary
- icode  in  4  opcode from fetch, valid in FETCH
- fetch_hlt / fetch_imem_err / fetch_ins_err  in  1 each  fetch status flags, valid in FETCH
- new_pc  in  PC_W  next PC from the PC-update unit, valid in PCUPD
- dmem_ack  in  1  data-memory completion
- dmem_err  in  1  data-memory fault; qualified by dmem_ack
- f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  one-hot stage strobes
- dmem_req  out  1  data-memory request; held until ack or timeout
- pc  out  PC_W  architectural PC
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- running  out  1  high when state is neither IDLE nor HALTED
- cyc_cnt, inst_cnt  out  CNT_W  saturating counters

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- Outputs are Moore-decoded from the state: f_en in FETCH, d_en in DECODE, e_en in EXECUTE, m_en and dmem_req in MEMORY, w_en in WRITEBACK, pc_en in PCUPD. All strobes are 0 in IDLE and HALTED.
- IDLE: when start=1, go to FETCH; otherwise hold.
- FETCH exit priority:
  - fetch_imem_err → stat=3, go to HALTED.
  - else fetch_ins_err → stat=4, go to HALTED.
  - else fetch_hlt → stat=2, inst_cnt+1, go to HALTED.
  - else go to DECODE.
- DECODE → EXECUTE.
- EXECUTE → MEMORY if icode ∈ {4,5,8,9,A,B}; otherwise → WRITEBACK. The MEMORY state is skipped entirely for other icodes.
- MEMORY: stay while dmem_ack=0, using a wait counter that counts from 0.
  - dmem_ack=1, dmem_err=0 → WRITEBACK.
  - dmem_ack=1, dmem_err=1 → stat=3, go to HALTED.
  - Wait counter reaches MEM_TIMEOUT without ack → stat=3, go to HALTED.
- WRITEBACK → PCUPD.
- PCUPD: pc<=new_pc and inst_cnt+1.
  - If stop=1 → IDLE.
  - Otherwise → FETCH.
- HALTED: absorbing. start and stop are ignored; only rst_n exits. pc and stat are frozen, so pc points at the faulting or halt instruction.
- Faults never produce w_en or pc_en for the faulting instruction.
- cyc_cnt increments every cycle that running=1. Both counters saturate at 2^CNT_W−1.
- dmem_ack outside MEMORY is ignored. dmem_err without dmem_ack is ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, stat=1, all strobes 0, dmem_req=0, running=0, cyc_cnt=0, inst_cnt=0, wait counter=0.
- Reset is asynchronous. Asserting rst_n mid-instruction, including during MEMORY, drops dmem_req and all strobes immediately, not at the next edge.
- start is sampled at the edge; start=1 in cycle n puts the controller in FETCH (f_en=1) in cycle n+1.
- Latency per instruction:
  - Non-memory: exactly 5 cycles (F, D, E, W, PC).
  - Memory: 6 cycles plus k, where k is the number of cycles dmem_ack stays low after dmem_req rises.
- new pc is visible the cycle after PCUPD, which is the same cycle f_en rises for the next instruction.
- start and stop both high in IDLE: exactly one instruction executes, then the controller returns to IDLE with stat=1. This is single-step mode.

## Test plan
- Reset and start: hold rst_n=0, release, pulse start at cycle 3 → pc=0, stat=1, counters 0; f_en=1 at cycle 4 only.
- OPq (icode 6), new_pc=2 → strobes in order f, d, e, w, pc over 5 cycles with m_en never high; then pc=2, inst_cnt=1, cyc_cnt=5.
- mrmovq (icode 5), dmem_ack 3 cycles after request, new_pc=10 → m_en/dmem_req high for 4 cycles, total 9 cycles, pc=10.
- fetch_hlt at pc=0x20 → stat=2, running=0, pc=0x20, inst_cnt+1; a later start produces no strobes.
- Faults:
  - icode 4 with no ack → HALTED after 15 wait cycles with stat=3.
  - ack with dmem_err=1 → stat=3, w_en never asserted.
  - fetch_imem_err and fetch_ins_err together → stat=3.
- start and stop held high → one instruction executes, then IDLE with stat=1.
- rst_n dropped in MEMORY → dmem_req=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/seq_ctrl.sv
// Stage sequencer and status controller for the sequential Y86-64 core.
// Owns pc and stat, steps the stage units with one-hot strobes, and times out data memory.
module seq_ctrl #(
  parameter int unsigned PC_W        = 64,
  parameter int unsigned CNT_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       icode,
  input  logic             fetch_hlt,
  input  logic             fetch_imem_err,
  input  logic             fetch_ins_err,
  input  logic [PC_W-1:0]  new_pc,
  input  logic             dmem_ack,
  input  logic             dmem_err,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic             dmem_req,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcupd, StHalted
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [2:0]       stat_q, stat_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [3:0]       icode_q;
  logic [CNT_W-1:0] cyc_q, inst_q;
  logic             inst_inc;
  logic             is_mem;

  // icode is only guaranteed during FETCH, so the memory decision uses a latched copy.
  always_comb begin
    is_mem = 1'b0;
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
      default:                            is_mem = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and architectural-state updates.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stat_d   = stat_q;
    wait_d   = '0;
    inst_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (fetch_imem_err) begin
          stat_d  = StatAdr;
          state_d = StHalted;
        end else if (fetch_ins_err) begin
          stat_d  = StatIns;
          state_d = StHalted;
        end else if (fetch_hlt) begin
          stat_d   = StatHlt;
          inst_inc = 1'b1;
          state_d  = StHalted;
        end else begin
          state_d = StDecode;
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: state_d = is_mem ? StMemory : StWriteback;
      StMemory: begin
        if (dmem_ack) begin
          if (dmem_err) begin
            stat_d  = StatAdr;
            state_d = StHalted;
          end else begin
            state_d = StWriteback;
          end
        end else if (wait_q == WaitLast) begin
          stat_d  = StatAdr;
          state_d = StHalted;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWriteback: state_d = StPcupd;
      StPcupd: begin
        pc_d     = new_pc;
        inst_inc = 1'b1;
        state_d  = stop ? StIdle : StFetch;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  // Moore output decode.
  always_comb begin
    f_en     = 1'b0;
    d_en     = 1'b0;
    e_en     = 1'b0;
    m_en     = 1'b0;
    w_en     = 1'b0;
    pc_en    = 1'b0;
    dmem_req = 1'b0;
    running  = 1'b1;
    case (state_q)
      StFetch:     f_en  = 1'b1;
      StDecode:    d_en  = 1'b1;
      StExecute:   e_en  = 1'b1;
      StMemory: begin
        m_en     = 1'b1;
        dmem_req = 1'b1;
      end
      StWriteback: w_en  = 1'b1;
      StPcupd:     pc_en = 1'b1;
      default:     running = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      stat_q  <= StatAok;
      wait_q  <= '0;
      icode_q <= '0;
      cyc_q   <= '0;
      inst_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      stat_q <= stat_d;
      wait_q <= wait_d;
      if (state_q == StFetch) icode_q <= icode;
      if (running && (cyc_q != '1)) cyc_q <= cyc_q + CNT_W'(1);
      if (inst_inc && (inst_q != '1)) inst_q <= inst_q + CNT_W'(1);
    end
  end

  assign pc       = pc_q;
  assign stat     = stat_q;
  assign cyc_cnt  = cyc_q;
  assign inst_cnt = inst_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: per-cycle strobe trace and end-of-instruction status
// are queued as expectations when stimulus is issued and popped when the DUT produces them.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic        fetch_hlt = 1'b0;
  logic        fetch_imem_err = 1'b0;
  logic        fetch_ins_err = 1'b0;
  logic [63:0] new_pc = 64'h0;
  logic        dmem_ack = 1'b0;
  logic        dmem_err = 1'b0;
  logic        f_en, d_en, e_en, m_en, w_en, pc_en, dmem_req, running;
  logic [63:0] pc;
  logic [2:0]  stat;
  logic [31:0] cyc_cnt, inst_cnt;

  seq_ctrl #(
    .PC_W       (64),
    .CNT_W      (32),
    .RESET_PC   (64'h0),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .icode         (icode),
    .fetch_hlt     (fetch_hlt),
    .fetch_imem_err(fetch_imem_err),
    .fetch_ins_err (fetch_ins_err),
    .new_pc        (new_pc),
    .dmem_ack      (dmem_ack),
    .dmem_err      (dmem_err),
    .f_en          (f_en),
    .d_en          (d_en),
    .e_en          (e_en),
    .m_en          (m_en),
    .w_en          (w_en),
    .pc_en         (pc_en),
    .dmem_req      (dmem_req),
    .pc            (pc),
    .stat          (stat),
    .running       (running),
    .cyc_cnt       (cyc_cnt),
    .inst_cnt      (inst_cnt)
  );

  always #5 clk = ~clk;

  // Trace word: {running, f, d, e, m, w, pc, dmem_req}
  localparam logic [7:0] VF = 8'b1_1000000;
  localparam logic [7:0] VD = 8'b1_0100000;
  localparam logic [7:0] VE = 8'b1_0010000;
  localparam logic [7:0] VM = 8'b1_0001001;
  localparam logic [7:0] VW = 8'b1_0000100;
  localparam logic [7:0] VP = 8'b1_0000010;
  localparam logic [7:0] VZ = 8'b0_0000000;

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [31:0] inst;
    logic [31:0] cyc;
    logic        run;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  logic [7:0] trace_q[$];
  res_t res_q[$];

  function automatic logic [7:0] obs_trace();
    return {running, f_en, d_en, e_en, m_en, w_en, pc_en, dmem_req};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_res(input logic [63:0] p, input logic [2:0] s, input logic [31:0] i,
                          input logic [31:0] c);
    res_t r;
    r.pc = p; r.stat = s; r.inst = i; r.cyc = c; r.run = 1'b0;
    res_q.push_back(r);
  endtask

  task automatic check_res(input string tag);
    res_t r;
    r = res_q.pop_front();
    chk({tag, "_pc"}, pc, r.pc);
    chk({tag, "_stat"}, 64'(stat), 64'(r.stat));
    chk({tag, "_inst"}, 64'(inst_cnt), 64'(r.inst));
    chk({tag, "_cyc"}, 64'(cyc_cnt), 64'(r.cyc));
    chk({tag, "_run"}, 64'(running), 64'(r.run));
  endtask

  task automatic push_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) trace_q.push_back(v);
  endtask

  task automatic push_instr(input bit mem, input int mem_cycles);
    trace_q.push_back(VF);
    trace_q.push_back(VD);
    trace_q.push_back(VE);
    if (mem) push_n(VM, mem_cycles);
    trace_q.push_back(VW);
    trace_q.push_back(VP);
  endtask

  // Pops one expected trace word per cycle; ack arrives on memory cycle k+1 (k<0: never).
  task automatic drain(input string tag, input int k, input bit err, input bit hlt,
                       input bit imem, input bit ins, input bit stop_v, input bit start_v);
    int mc;
    logic [7:0] e;
    mc = 0;
    while (trace_q.size() > 0) begin
      @(negedge clk);
      e = trace_q.pop_front();
      chk(tag, 64'(obs_trace()), 64'(e));
      start          = start_v;
      stop           = stop_v;
      fetch_hlt      = (e == VF) ? hlt : 1'b0;
      fetch_imem_err = (e == VF) ? imem : 1'b0;
      fetch_ins_err  = (e == VF) ? ins : 1'b0;
      if (e == VM) mc++;
      dmem_ack = (e == VM) && (k >= 0) && (mc == k + 1);
      dmem_err = (e == VM) ? err : 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0;
    fetch_hlt = 1'b0; fetch_imem_err = 1'b0; fetch_ins_err = 1'b0;
    #1;
    push_res(64'h0, 3'd1, 32'd0, 32'd0);
    check_res("reset");
    chk("reset_strobes", 64'(obs_trace()), 64'(VZ));
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, idle, then start on the third cycle: OPq with stop -> back to IDLE.
    @(negedge clk);
    push_res(64'h0, 3'd1, 32'd0, 32'd0);
    check_res("por");
    rst_n = 1'b1;
    push_n(VZ, 2);
    drain("idle", -1, 0, 0, 0, 0, 0, 0);
    start = 1'b1; icode = 4'h6; new_pc = 64'h2; stop = 1'b1;
    push_instr(0, 0);
    push_res(64'h2, 3'd1, 32'd1, 32'd5);
    drain("opq", -1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check_res("opq");

    // mrmovq with ack after 3 low cycles: 4 memory cycles, 9 total.
    start = 1'b1; icode = 4'h5; new_pc = 64'hA; stop = 1'b1;
    push_instr(1, 4);
    push_res(64'hA, 3'd1, 32'd2, 32'd14);
    drain("mrmovq", 3, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check_res("mrmovq");

    // rrmovq flows straight into a halt fetched at 0x20; later start is ignored.
    start = 1'b1; icode = 4'h2; new_pc = 64'h20; stop = 1'b0;
    push_instr(0, 0);
    drain("rrmovq", -1, 0, 0, 0, 0, 0, 0);
    icode = 4'h0;
    trace_q.push_back(VF);
    push_res(64'h20, 3'd2, 32'd4, 32'd20);
    push_res(64'h20, 3'd2, 32'd4, 32'd20);
    drain("halt", -1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check_res("halt");
    start = 1'b1; new_pc = 64'h77;
    push_n(VZ, 3);
    drain("halted_start", -1, 0, 0, 0, 0, 0, 1);
    check_res("halted_frozen");

    // pushq never acknowledged: 15 memory cycles then ADR.
    do_reset();
    start = 1'b1; icode = 4'h4; new_pc = 64'h55; stop = 1'b0;
    trace_q.push_back(VF); trace_q.push_back(VD); trace_q.push_back(VE);
    push_n(VM, 15);
    push_n(VZ, 2);
    push_res(64'h0, 3'd3, 32'd0, 32'd18);
    drain("timeout", -1, 0, 0, 0, 0, 0, 0);
    check_res("timeout");

    // popq acked with dmem_err (err without ack earlier is ignored): ADR, no w_en.
    do_reset();
    start = 1'b1; icode = 4'hB; new_pc = 64'h55;
    trace_q.push_back(VF); trace_q.push_back(VD); trace_q.push_back(VE);
    push_n(VM, 3);
    push_n(VZ, 2);
    push_res(64'h0, 3'd3, 32'd0, 32'd6);
    drain("dmem_err", 2, 1, 0, 0, 0, 0, 0);
    check_res("dmem_err");

    // All fetch flags: imem wins over ins and hlt.
    do_reset();
    start = 1'b1; icode = 4'h6;
    trace_q.push_back(VF); trace_q.push_back(VZ);
    push_res(64'h0, 3'd3, 32'd0, 32'd1);
    drain("imem_ins", -1, 0, 1, 1, 1, 0, 0);
    check_res("imem_ins");

    // ins over hlt: INS, no retirement.
    do_reset();
    start = 1'b1;
    trace_q.push_back(VF); trace_q.push_back(VZ);
    push_res(64'h0, 3'd4, 32'd0, 32'd1);
    drain("ins_hlt", -1, 0, 1, 0, 1, 0, 0);
    check_res("ins_hlt");

    // Single step: start and stop high together.
    do_reset();
    start = 1'b1; stop = 1'b1; icode = 4'h6; new_pc = 64'h40;
    push_instr(0, 0);
    drain("sstep", -1, 0, 0, 0, 0, 1, 1);
    push_n(VZ, 2);
    push_res(64'h40, 3'd1, 32'd1, 32'd5);
    drain("sstep_idle", -1, 0, 0, 0, 0, 1, 0);
    check_res("sstep");

    // Reset while call waits in MEMORY: outputs drop without a clock edge.
    start = 1'b1; stop = 1'b0; icode = 4'h8; new_pc = 64'h99;
    trace_q.push_back(VF); trace_q.push_back(VD); trace_q.push_back(VE);
    push_n(VM, 2);
    drain("mem_rst", -1, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req", 64'(dmem_req), 64'h0);
    chk("async_strobes", 64'(obs_trace()), 64'(VZ));
    chk("async_pc", pc, 64'h0);
    chk("async_stat", 64'(stat), 64'h1);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
